// File: rtl/spike_isi_analyzer.sv
// spike_isi_analyzer: windowed inter-spike-interval statistics and firing-pattern classification
module spike_isi_analyzer #(
    parameter int ISI_W     = 16,
    parameter int CNT_W     = 8,
    parameter int BURST_ISI = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spike_in,
    input  logic             enable,
    input  logic [15:0]      window_len,
    output logic             busy,
    output logic             win_done,
    output logic [CNT_W-1:0] spike_count,
    output logic [ISI_W-1:0] isi_first,
    output logic [ISI_W-1:0] isi_last,
    output logic [ISI_W-1:0] isi_min,
    output logic [1:0]       pattern
);
    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;
    state_t state;
    logic spike_prev, have_spike, have_isi;
    logic [15:0] win_cnt;
    logic [ISI_W-1:0] isi_cnt, first_acc, last_acc, min_acc, max_acc;
    logic [CNT_W-1:0] cnt;
    logic spike_edge, rec, first_spike, quiet, burst, adapt;
    logic [CNT_W-1:0] n_cnt;
    logic [ISI_W-1:0] n_first, n_last, n_min, n_max;
    logic [1:0] n_pat;
    logic [15:0] win_len_eff;
    always_comb begin
        spike_edge  = spike_in & ~spike_prev;
        rec         = spike_edge & have_spike;
        first_spike = (state == REPORT) & spike_edge;
        win_len_eff = (window_len < 16'd2) ? 16'd2 : window_len;
        n_cnt       = (spike_edge && cnt != '1) ? cnt + 1'b1 : cnt;
        n_first     = (rec && !have_isi) ? isi_cnt : first_acc;
        n_last      = rec ? isi_cnt : last_acc;
        n_min       = (rec && isi_cnt < min_acc) ? isi_cnt : min_acc;
        n_max       = (rec && isi_cnt > max_acc) ? isi_cnt : max_acc;
        quiet       = n_cnt < CNT_W'(2);
        burst       = (n_min < ISI_W'(BURST_ISI)) && ({2'b00, n_max} >= {n_min, 2'b00});
        adapt       = {2'b00, n_last} > ({2'b00, n_first} + {4'b0000, n_first[ISI_W-1:2]});
        n_pat       = quiet ? 2'd0 : burst ? 2'd3 : adapt ? 2'd2 : 2'd1;
    end
    always_ff @(posedge clk) begin
        spike_prev <= reset ? 1'b0 : spike_in;
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            win_done    <= 1'b0;
            spike_count <= '0;
            isi_first   <= '0;
            isi_last    <= '0;
            isi_min     <= '0;
            pattern     <= 2'd0;
            win_cnt     <= '0;
            cnt         <= '0;
            have_spike  <= 1'b0;
            have_isi    <= 1'b0;
            isi_cnt     <= '0;
            first_acc   <= '0;
            last_acc    <= '0;
            min_acc     <= '1;
            max_acc     <= '0;
        end else begin
            win_done <= 1'b0;
            if (state == RUN) begin
                if (!enable) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (win_cnt == 16'd1) begin
                    state       <= REPORT;
                    win_done    <= 1'b1;
                    spike_count <= n_cnt;
                    isi_first   <= quiet ? '0 : n_first;
                    isi_last    <= quiet ? '0 : n_last;
                    isi_min     <= quiet ? '0 : n_min;
                    pattern     <= n_pat;
                end else begin
                    win_cnt    <= win_cnt - 1'b1;
                    cnt        <= n_cnt;
                    have_spike <= have_spike | spike_edge;
                    have_isi   <= have_isi | rec;
                    isi_cnt    <= spike_edge ? ISI_W'(1) : (isi_cnt == '1) ? isi_cnt : isi_cnt + 1'b1;
                    first_acc  <= n_first;
                    last_acc   <= n_last;
                    min_acc    <= n_min;
                    max_acc    <= n_max;
                end
            end else if (enable) begin
                // an edge seen during REPORT opens the next window
                state      <= RUN;
                busy       <= 1'b1;
                win_cnt    <= win_len_eff;
                cnt        <= CNT_W'(first_spike);
                have_spike <= first_spike;
                have_isi   <= 1'b0;
                isi_cnt    <= ISI_W'(1);
                first_acc  <= '0;
                last_acc   <= '0;
                min_acc    <= '1;
                max_acc    <= '0;
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spike_isi_analyzer.sv
// tb_spike_isi_analyzer: directed and randomized windows checked against an edge-time list model
module tb_spike_isi_analyzer;
    logic clk = 1'b0;
    logic reset, spike_in, enable;
    logic [15:0] window_len;
    logic busy, win_done;
    logic [7:0] spike_count;
    logic [15:0] isi_first, isi_last, isi_min;
    logic [1:0] pattern;
    int checks = 0;
    int errors = 0;
    bit lv [0:1100];
    bit prev_lv;
    int q[$];
    int e_cnt, e_first, e_last, e_min, e_pat;

    spike_isi_analyzer dut (
        .clk(clk), .reset(reset), .spike_in(spike_in), .enable(enable), .window_len(window_len),
        .busy(busy), .win_done(win_done), .spike_count(spike_count), .isi_first(isi_first),
        .isi_last(isi_last), .isi_min(isi_min), .pattern(pattern)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        prev_lv = spike_in;
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        foreach (lv[i]) lv[i] = 1'b0;
    endtask

    task automatic model();
        int n, mn, mx, isi;
        n = q.size();
        e_cnt = (n > 255) ? 255 : n;
        if (n < 2) begin
            e_first = 0; e_last = 0; e_min = 0; e_pat = 0;
        end else begin
            e_first = q[1] - q[0];
            e_last  = q[n-1] - q[n-2];
            mn = e_first; mx = e_first;
            for (int k = 1; k < n; k++) begin
                isi = q[k] - q[k-1];
                if (isi < mn) mn = isi;
                if (isi > mx) mx = isi;
            end
            e_min = mn;
            e_pat = (mn < 16 && mx >= 4 * mn) ? 3 : (e_last > e_first + e_first / 4) ? 2 : 1;
        end
    endtask

    task automatic run_window(input int len, input bit fc);
        int n;
        bit cur;
        n = (len < 2) ? 2 : len;
        cur = spike_in;
        q.delete();
        if (fc && cur && !prev_lv) q.push_back(0);
        for (int i = 1; i <= n; i++)
            if (lv[i] && !((i == 1) ? cur : lv[i-1])) q.push_back(i);
        model();
        enable = 1'b1;
        window_len = len[15:0];
        tick();
        for (int i = 1; i <= n; i++) begin
            spike_in = lv[i];
            if (i == 1 || i == n) begin
                check("busy_run", busy, 1);
                check("done_run", win_done, 0);
            end
            if (i == n / 2) window_len = 16'($urandom);
            tick();
        end
        check("done_rep", win_done, 1);
        check("busy_rep", busy, 1);
        check("count", spike_count, e_cnt);
        check("isi_first", isi_first, e_first);
        check("isi_last", isi_last, e_last);
        check("isi_min", isi_min, e_min);
        check("pattern", pattern, e_pat);
    endtask

    task automatic go_idle();
        enable = 1'b0;
        spike_in = 1'b0;
        tick();
        check("busy_idle", busy, 0);
        check("done_idle", win_done, 0);
    endtask

    task automatic rand_train(input int n, input int gmax);
        int i, w;
        clr();
        i = 1;
        while (i <= n) begin
            i += $urandom_range(1, gmax);
            w = $urandom_range(1, 3);
            for (int k = 0; k < w && i <= n; k++) begin
                lv[i] = 1'b1;
                i++;
            end
        end
    endtask

    initial begin
        int len, gsel;
        bit fc;
        reset = 1'b1; enable = 1'b0; spike_in = 1'b0; window_len = 16'd0;
        for (int c = 0; c < 3; c++) begin
            spike_in = ~spike_in;
            tick();
            check("rst_busy", busy, 0);
            check("rst_done", win_done, 0);
            check("rst_count", spike_count, 0);
            check("rst_pattern", pattern, 0);
        end
        reset = 1'b0; spike_in = 1'b0;
        tick();
        check("rst_first", isi_first, 0);
        check("rst_last", isi_last, 0);
        check("rst_min", isi_min, 0);

        clr();
        for (int k = 0; k < 10; k++) lv[10 + 20 * k] = 1'b1;
        run_window(200, 0);
        check("tonic_count", spike_count, 10);
        check("tonic_isi", isi_min, 20);
        check("tonic_pattern", pattern, 1);
        go_idle();

        clr();
        lv[5] = 1; lv[15] = 1; lv[29] = 1; lv[47] = 1; lv[69] = 1; lv[95] = 1;
        run_window(120, 0);
        check("adapt_first", isi_first, 10);
        check("adapt_last", isi_last, 26);
        check("adapt_pattern", pattern, 2);
        go_idle();

        clr();
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 3; k++) lv[5 + 68 * g + 4 * k] = 1'b1;
        run_window(300, 0);
        check("burst_min", isi_min, 4);
        check("burst_pattern", pattern, 3);
        go_idle();

        clr();
        for (int i = 10; i < 15; i++) lv[i] = 1'b1;
        run_window(50, 0);
        check("held_count", spike_count, 1);
        go_idle();

        clr();
        run_window(30, 0);
        check("none_pattern", pattern, 0);
        go_idle();

        clr();
        lv[7] = 1'b1;
        run_window(30, 0);
        check("single_count", spike_count, 1);
        go_idle();

        clr();
        for (int k = 1; k <= 300; k++) lv[2 * k] = 1'b1;
        run_window(1000, 0);
        check("sat_count", spike_count, 255);
        go_idle();

        clr();
        lv[1] = 1'b1;
        run_window(0, 0);
        go_idle();
        clr();
        run_window(1, 0);
        go_idle();

        clr();
        lv[10] = 1'b1; lv[40] = 1'b1;
        run_window(40, 0);
        check("final_edge_count", spike_count, 2);
        check("final_edge_isi", isi_last, 30);
        go_idle();

        spike_in = 1'b1;
        tick();
        clr();
        lv[1] = 1; lv[2] = 1; lv[3] = 1; lv[20] = 1;
        run_window(60, 0);
        check("start_high_count", spike_count, 1);
        go_idle();

        enable = 1'b1; window_len = 16'd100;
        tick();
        for (int i = 1; i <= 50; i++) begin
            spike_in = (i % 7 == 0);
            tick();
        end
        enable = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        for (int i = 0; i < 120; i++) begin
            spike_in = 1'($urandom);
            check("abort_done", win_done, 0);
            if (i % 30 == 0) begin
                check("abort_count", spike_count, e_cnt);
                check("abort_last", isi_last, e_last);
                check("abort_pattern", pattern, e_pat);
            end
            tick();
        end
        spike_in = 1'b0;
        tick();
        rand_train(80, 10);
        run_window(80, 0);
        go_idle();

        fc = 1'b0;
        for (int r = 0; r < 30; r++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 250);
            gsel = $urandom_range(0, 2);
            rand_train((len < 2) ? 2 : len, (gsel == 0) ? 3 : (gsel == 1) ? 12 : 50);
            run_window(len, fc);
            if ($urandom_range(0, 1) == 1) begin
                spike_in = 1'($urandom);
                fc = 1'b1;
            end else begin
                go_idle();
                fc = 1'b0;
            end
        end
        go_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spike_isi_analyzer.md
# spike_isi_analyzer

Downstream consumer of the AdEx neuron core's one-cycle spike output. It measures inter-spike intervals (ISIs) and spike count over a programmable analysis window. At each window close it reports first, last and minimum ISI, the spike count, and a 2-bit firing-pattern class (quiet, tonic, adapting, bursting). Host-side tests use it to confirm that loaded parameter sets produce the intended dynamics without streaming raw membrane samples off-chip.

## Interface
Parameters:
- ISI_W, 16: width of ISI counters and ISI outputs.
- CNT_W, 8: width of the spike counter.
- BURST_ISI, 16: an ISI strictly below this value (in cycles) qualifies as intra-burst.

Ports:
- clk  in  1  system clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- spike_in  in  1  spike from neuron core; only rising edges count.
- enable  in  1  run analysis while high.
- window_len  in  16  window length in cycles; sampled at window start; values 0 and 1 are treated as 2.
- busy  out  1  high in RUN and REPORT.
- win_done  out  1  one-cycle pulse during REPORT.
- spike_count  out  CNT_W  spikes in the last completed window; saturating.
- isi_first  out  ISI_W  first ISI of the last completed window.
- isi_last  out  ISI_W  last ISI of the last completed window.
- isi_min  out  ISI_W  smallest ISI of the last completed window.
- pattern  out  2  0 quiet, 1 tonic, 2 adapting, 3 bursting.

## Operation
- Edge detect: spike_prev is registered every cycle, including in IDLE; edge = spike_in & ~spike_prev. A level held high across multiple cycles counts once. A level already high when RUN is entered does not count.
- States: IDLE, RUN, REPORT.
  - IDLE to RUN when enable=1. On entry: win_cnt := max(window_len,2), clear all accumulators, isi_min_acc := all-ones, have_spike := 0.
  - RUN:
    - win_cnt decrements each cycle.
    - In the cycle where win_cnt==1, go to REPORT.
    - enable=0 at any point goes to IDLE. The window is aborted: no win_done, outputs hold their previous values.
  - REPORT lasts exactly one cycle:
    - Outputs register.
    - win_done=1.
    - Next state is RUN with a fresh window if enable=1, otherwise IDLE.
- ISI measurement in RUN:
  - isi_cnt increments every cycle and saturates at 2^ISI_W-1.
  - On an edge with have_spike=0: set have_spike, isi_cnt := 1, count++. No ISI is recorded.
  - On an edge with have_spike=1: ISI := isi_cnt, so edges at cycles t1 and t2 give ISI = t2-t1. Then:
    - If this is the first ISI, record it as isi_first.
    - isi_last := ISI.
    - Update isi_min_acc and isi_max_acc.
    - isi_cnt := 1, count++.
  - count saturates at 2^CNT_W-1. ISI tracking continues after count saturates.
- An edge in the final RUN cycle belongs to the current window. An edge during REPORT is the first spike of the next window; it is not recorded if the block goes to IDLE.
- Classification at REPORT, using n = spikes in the window; first match wins:
  - n<2: pattern 0. isi_first, isi_last and isi_min output 0.
  - isi_min < BURST_ISI and isi_max >= 4*isi_min: pattern 3. Compare with ISI_W+2-bit arithmetic, no overflow.
  - isi_last > isi_first + (isi_first>>2), i.e. more than 1.25x: pattern 2.
  - Otherwise: pattern 1.
- Reset values: state IDLE; all outputs 0; spike_prev 0.
- reset during RUN or REPORT returns to the reset values on the next edge. Any in-progress window is discarded.

## Timing
- If enable is sampled high in IDLE at edge k, RUN spans cycles k+1 through k+N, where N = max(window_len,2).
- REPORT occurs at cycle k+N+1: win_done and the new outputs are visible in that cycle.
- When enable stays high, back-to-back windows are N+1 cycles apart. The REPORT cycle is not part of any window's count.
- Results hold from a REPORT until the next REPORT or reset.
- No combinational path from any input to any output.

## Test plan
- Reset: assert reset 3 cycles with spike_in toggling. All outputs 0, busy=0, no win_done.
- Tonic: window_len=200; 1-cycle spikes every 20 cycles from RUN cycle 10. Expect spike_count=10, isi_first=isi_last=isi_min=20, pattern=1, win_done at RUN-entry+201.
- Adapting: ISIs 10,14,18,22,26 (6 spikes); BURST_ISI=16. Expect count=6, isi_first=10, isi_last=26, isi_min=10, pattern=2, since max 26 < 40 rules out bursting.
- Bursting: repeated groups of 3 spikes at ISI 4 separated by gaps of 60. Expect isi_min=4, isi_max=60 (≥16), pattern=3.
- Boundaries:
  - spike_in held high 5 cycles: counts as 1.
  - No spikes: pattern=0, ISI outputs 0.
  - Single spike: count=1, pattern=0.
  - 300 spikes with ISI 2 and window_len=1000: count=255.
  - window_len=0: window is 2 cycles.
  - Edge on the final RUN cycle: counted in that window.
- Abort: drop enable mid-window. Expect no win_done, outputs unchanged from the previous REPORT. Re-raising enable starts a fresh full window.
